// File: rtl/rv_operand_stage.sv
// rv_operand_stage: decode and operand-fetch stage that feeds a single-cycle ALU.
// It decodes the RV32I OP / OP-IMM arithmetic-logic subset and reads the
// integrated register file. When the instruction needs an immediate, that value
// replaces the rs2 operand. The stage then registers an
// {alu_control, operand1, operand2, rd} bundle behind a valid/ready handshake.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   instruction handshake (in_ready is combinational)
//   instr                 32-bit instruction word
//   wb_en/wb_addr/wb_data writeback port from later stages (x0 writes dropped)
//   out_valid / out_ready output bundle handshake
//   alu_control           0 AND, 1 OR, 2 ADD, 3 SUB
//   operand1, operand2    rs1 value; rs2 value or sign-extended I-immediate
//   rd_addr, rd_we        destination register and write-back flag
//   illegal               instruction outside the supported subset
module rv_operand_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] operand1,
  output logic [XLEN-1:0] operand2,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;

  localparam logic [3:0] AluAnd = 4'd0;
  localparam logic [3:0] AluOr  = 4'd1;
  localparam logic [3:0] AluAdd = 4'd2;
  localparam logic [3:0] AluSub = 4'd3;

  // Instruction fields
  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] imm_i;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign imm_i    = {{(XLEN-12){instr[31]}}, instr[31:20]};

  // Register file
  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign wr_en = wb_en && (wb_addr != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Read ports. A write landing this cycle is forwarded so the bundle never
  // captures the stale array value; wr_en already excludes x0.
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  always_comb begin
    rs1_val = '0;
    if (rs1_addr != 5'd0) begin
      rs1_val = (wr_en && (wb_addr == rs1_addr)) ? wb_data : regs_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_val = '0;
    if (rs2_addr != 5'd0) begin
      rs2_val = (wr_en && (wb_addr == rs2_addr)) ? wb_data : regs_q[rs2_addr];
    end
  end

  // Decode
  logic [3:0]      dec_ctl;
  logic            dec_ill;
  logic            dec_use_imm;
  logic [XLEN-1:0] dec_op1;
  logic [XLEN-1:0] dec_op2;
  logic            dec_we;

  always_comb begin
    dec_ctl     = AluAdd;
    dec_ill     = 1'b1;
    dec_use_imm = 1'b0;
    case (opcode)
      OpcOp: begin
        dec_ill = 1'b0;
        case ({funct7, funct3})
          {F7Base, F3AddSub}: dec_ctl = AluAdd;
          {F7Alt, F3AddSub}:  dec_ctl = AluSub;
          {F7Base, F3And}:    dec_ctl = AluAnd;
          {F7Base, F3Or}:     dec_ctl = AluOr;
          default:            dec_ill = 1'b1;
        endcase
      end
      OpcOpImm: begin
        dec_ill     = 1'b0;
        dec_use_imm = 1'b1;
        case (funct3)
          F3AddSub: dec_ctl = AluAdd;
          F3And:    dec_ctl = AluAnd;
          F3Or:     dec_ctl = AluOr;
          default:  dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase

    // Illegal bundles still flow downstream, as an inert ADD of zeros.
    dec_op1 = '0;
    dec_op2 = '0;
    dec_we  = 1'b0;
    if (dec_ill) begin
      dec_ctl = AluAdd;
    end else begin
      dec_op1 = rs1_val;
      dec_op2 = dec_use_imm ? imm_i : rs2_val;
      dec_we  = 1'b1;
    end
  end

  // Output register and handshake
  logic            out_valid_q;
  logic [3:0]      alu_control_q;
  logic [XLEN-1:0] operand1_q;
  logic [XLEN-1:0] operand2_q;
  logic [4:0]      rd_addr_q;
  logic            rd_we_q;
  logic            illegal_q;
  logic            xfer;

  assign in_ready = !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      alu_control_q <= 4'd0;
      operand1_q    <= '0;
      operand2_q    <= '0;
      rd_addr_q     <= 5'd0;
      rd_we_q       <= 1'b0;
      illegal_q     <= 1'b0;
    end else if (xfer) begin
      out_valid_q   <= 1'b1;
      alu_control_q <= dec_ctl;
      operand1_q    <= dec_op1;
      operand2_q    <= dec_op2;
      rd_addr_q     <= instr[11:7];
      rd_we_q       <= dec_we;
      illegal_q     <= dec_ill;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign alu_control = alu_control_q;
  assign operand1    = operand1_q;
  assign operand2    = operand2_q;
  assign rd_addr     = rd_addr_q;
  assign rd_we       = rd_we_q;
  assign illegal     = illegal_q;

endmodule

// File: doc/rv_operand_stage.md
Name: rv_operand_stage

Overview:
Decode/operand-fetch stage sitting directly upstream of the single-cycle ALU. It accepts a 32-bit RV32I instruction, decodes the supported arithmetic/logic subset, reads the integrated 32x32 register file, and selects the immediate when required. It then presents a registered {alu_control, operand1, operand2, rd} bundle to the ALU through a valid/ready handshake. Writeback from later stages enters through a dedicated write port.

Parameters:
XLEN, 32, datapath width of registers, operands and immediates.
NREGS, 32, register count; index width is fixed at 5 bits.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  instruction present on instr
in_ready  output  1  stage can accept instr this cycle
instr  input  32  RV32I instruction word
wb_en  input  1  register write enable
wb_addr  input  5  register write index
wb_data  input  XLEN  register write data
out_valid  output  1  output bundle valid
out_ready  input  1  ALU side consumes bundle
alu_control  output  4  ALU operation: 0 AND, 1 OR, 2 ADD, 3 SUB
operand1  output  XLEN  rs1 value
operand2  output  XLEN  rs2 value or sign-extended I-immediate
rd_addr  output  5  destination register
rd_we  output  1  result is to be written back
illegal  output  1  instr outside supported subset

Behaviour:
- Reset (async, immediate): all 32 registers = 0; out_valid=0, alu_control=0, operand1=0, operand2=0, rd_addr=0, rd_we=0, illegal=0.
- Handshake: in_ready = !out_valid || out_ready (combinational). Transfer occurs when in_valid && in_ready. The output bundle loads on the next rising edge, so latency is 1 cycle.
- Output register: when a transfer occurs, out_valid <= 1. When out_ready is high and no transfer occurs, out_valid <= 0. While out_valid && !out_ready, all outputs hold stable.
- Decode, opcode = instr[6:0]:
  - 0110011 (OP): funct3 000 with funct7 0000000 -> ADD(2); funct3 000 with funct7 0100000 -> SUB(3); funct3 111 with funct7 0 -> AND(0); funct3 110 with funct7 0 -> OR(1). operand2 = rs2 value.
  - 0010011 (OP-IMM): funct3 000 -> ADDI(2); 111 -> ANDI(0); 110 -> ORI(1). operand2 = sign-extended instr[31:20].
  - rd_we = 1 for every legal instruction, including rd=x0; the register file itself discards writes to x0.
  - Any other opcode/funct combination: illegal=1, alu_control=2, operand1=0, operand2=0, rd_we=0. rd_addr still = instr[11:7]. The bundle is still emitted with out_valid=1; the stage does not stall.
- Register file:
  - Two combinational read ports, indexed by instr[19:15] and instr[24:20].
  - Synchronous write at the rising edge when wb_en && wb_addr != 0.
  - x0 always reads 0; wb_en with wb_addr=0 is ignored.
- Bypass: if wb_en && wb_addr != 0 && wb_addr equals a read index in the same cycle as a transfer, that operand takes wb_data, not the stale array value. Bypass never applies to x0.
- Writes proceed regardless of handshake state, including while the output is stalled. A stalled bundle is not refreshed by later writes.
- Reset asserted mid-transfer discards the in-flight bundle and clears all registers; the first cycle after deassertion has in_ready=1.

Test Plan:
- Reset with out_ready=1, then wb x5=7 and x6=3. Issue ADD x1,x5,x6 -> one cycle later out_valid=1, alu_control=2, operand1=7, operand2=3, rd_addr=1, rd_we=1. Repeat with SUB -> alu_control=3, same operands.
- ADDI x2,x5,-1 (imm 0xFFF) -> operand2=0xFFFFFFFF, alu_control=2. ANDI x2,x5,0x0F0 -> alu_control=0, operand2=0x000000F0. ORI -> alu_control=1.
- Same cycle: wb x7=0xDEADBEEF and issue OR x3,x7,x0 -> operand1=0xDEADBEEF (bypass), operand2=0. Write to x0 with 0x55, then read x0 -> 0.
- Backpressure: hold out_ready=0 after a bundle. Require in_ready=0 and outputs stable for 5 cycles while a second instr waits. Raise out_ready -> second bundle appears next cycle. Back-to-back transfers with out_ready=1 give one bundle per cycle.
- Illegal: opcode 0000011 (LW) -> illegal=1, rd_we=0, operands 0, out_valid=1. OP with funct7=0000001 (MUL) -> illegal=1.
- Assert reset while out_valid=1 with stalled output -> out_valid=0 immediately (asynchronously). All registers read 0 afterwards.
